// File: rtl/tff_count_pkg.sv
// Shared definitions for the T flip-flop counter controller.
// Holds the command opcodes and the controller state encoding.
package tff_count_pkg;

   localparam logic [1:0] OP_CLEAR = 2'b00;
   localparam logic [1:0] OP_LOAD  = 2'b01;
   localparam logic [1:0] OP_UP    = 2'b10;
   localparam logic [1:0] OP_DOWN  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_APPLY = 2'b01,
      ST_RUN   = 2'b10,
      ST_DONE  = 2'b11
   } state_t;

endpackage

// File: rtl/tff.sv
// Single T flip-flop cell: Q inverts on a clock edge whenever T is high.
// Asynchronous active-low reset clears Q.
module tff (
   input  logic clk,
   input  logic rstn,
   input  logic T,
   output logic Q
);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         Q <= 1'b0;
      else if (T)
         Q <= ~Q;
   end

endmodule

// File: rtl/tff_count_ctrl.sv
// Command-driven counter whose value lives only in a bank of T flip-flops.
// The FSM computes a per-bit toggle vector to clear, load, or step the count.
module tff_count_ctrl
   import tff_count_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic             abort,
   output logic [WIDTH-1:0] q,
   output logic             busy,
   output logic             done,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_t           state;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] remaining;
   logic [WIDTH-1:0] t;
   logic [WIDTH-1:0] q_up;
   logic [WIDTH-1:0] q_dn;
   logic             wrap_step;
   wire  [WIDTH-1:0] q_bank;

   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : g_bit
         tff u_tff (
            .clk  (clk),
            .rstn (rstn),
            .T    (t[i]),
            .Q    (q_bank[i])
         );
      end
   endgenerate

   assign q         = q_bank;
   assign cmd_ready = (state == ST_IDLE);
   assign busy      = (state == ST_APPLY) || (state == ST_RUN);
   assign q_up      = q_bank + ONE;
   assign q_dn      = q_bank - ONE;

   // Toggle only the bits that differ from the desired next value; an abort
   // cycle freezes the bank so the count stays where the last step left it.
   always_comb begin
      t         = '0;
      wrap_step = 1'b0;
      case (state)
         ST_APPLY: t = q_bank ^ ((op_q == OP_CLEAR) ? '0 : data_q);
         ST_RUN: begin
            if (!abort) begin
               if (op_q == OP_UP) begin
                  t         = q_bank ^ q_up;
                  wrap_step = (q_bank == '1);
               end else begin
                  t         = q_bank ^ q_dn;
                  wrap_step = (q_bank == '0);
               end
            end
         end
         default: t = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= ST_IDLE;
         op_q      <= OP_CLEAR;
         data_q    <= '0;
         remaining <= '0;
         done      <= 1'b0;
         wrap      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  op_q   <= cmd_op;
                  data_q <= cmd_data;
                  if (cmd_op == OP_CLEAR || cmd_op == OP_LOAD) begin
                     wrap  <= 1'b0;
                     state <= ST_APPLY;
                  end else if (cmd_data == '0) begin
                     done  <= 1'b1;
                     state <= ST_DONE;
                  end else begin
                     remaining <= cmd_data;
                     state     <= ST_RUN;
                  end
               end
            end
            ST_APPLY: begin
               done  <= 1'b1;
               state <= ST_DONE;
            end
            ST_RUN: begin
               remaining <= remaining - ONE;
               if (wrap_step)
                  wrap <= 1'b1;
               if (abort || remaining == ONE) begin
                  done  <= 1'b1;
                  state <= ST_DONE;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/tff_count_ctrl.md
TFF_COUNT_CTRL -- requirements
Module: tff_count_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the counter bit width (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-003 The block SHALL have port rstn, input, 1, reset (asynchronous, active-low).
REQ-004 The block SHALL have port cmd_valid, input, 1, command request.
REQ-005 The block SHALL have port cmd_ready, output, 1, command accept (high only in IDLE).
REQ-006 The block SHALL have port cmd_op, input, 2, op code: 00 CLEAR, 01 LOAD, 10 UP, 11 DOWN.
REQ-007 The block SHALL have port cmd_data, input, WIDTH, load value (LOAD) or step count N (UP/DOWN); ignored for CLEAR.
REQ-008 The block SHALL have port abort, input, 1, terminates a RUN early.
REQ-009 The block SHALL have port q, output, WIDTH, counter value taken directly from the T flip-flop bank.
REQ-010 The block SHALL have port busy, output, 1, high in APPLY and RUN.
REQ-011 The block SHALL have port done, output, 1, single-cycle completion pulse.
REQ-012 The block SHALL have port wrap, output, 1, sticky wrap-around flag.

Function
REQ-013 The block SHALL hold q only in a bank of WIDTH T flip-flops and change it only through per-bit toggle enables t[i].
REQ-014 A command SHALL be accepted at a rising edge where cmd_valid and cmd_ready are both high; the block SHALL latch cmd_op and cmd_data at that edge.
REQ-015 The FSM SHALL have the states IDLE, APPLY, RUN and DONE.
REQ-016 In IDLE, cmd_ready SHALL be 1, t SHALL be 0, and q SHALL hold.
REQ-017 An accepted CLEAR or LOAD SHALL go IDLE->APPLY; APPLY lasts one cycle with t = q XOR target (target 0 for CLEAR, cmd_data for LOAD), then goes ->DONE.
REQ-018 An accepted UP or DOWN with N>0 SHALL go IDLE->RUN with remaining=N.
REQ-019 An accepted UP or DOWN with N=0 SHALL go IDLE->DONE with no toggles.
REQ-020 In each RUN cycle, t SHALL be q XOR (q+1) for UP and q XOR (q-1) for DOWN, computed modulo 2^WIDTH, and remaining SHALL decrement.
REQ-021 RUN SHALL go ->DONE in the cycle when remaining==1, so exactly N toggling cycles occur.
REQ-022 When abort is high in a RUN cycle, t SHALL be 0 in that cycle and the next state SHALL be DONE; abort SHALL be ignored outside RUN.
REQ-023 DONE SHALL last one cycle with done=1 and cmd_ready=0, then go ->IDLE.
REQ-024 Latency: q SHALL hold its final value at the edge ending the last APPLY or RUN cycle, and done SHALL be high in the following cycle.
REQ-025 wrap SHALL be set by a RUN step from all-ones to 0 (UP) or from 0 to all-ones (DOWN).
REQ-026 wrap SHALL be cleared when a CLEAR or LOAD is accepted; set and clear never coincide, because acceptance occurs only in IDLE.
REQ-027 busy SHALL be a combinational decode of the state; done and wrap SHALL be registered.
REQ-028 The block SHALL ignore cmd_valid while cmd_ready=0, and SHALL NOT queue requests.

Reset
REQ-029 When rstn is low, the block SHALL asynchronously force state=IDLE, q=0, remaining=0, done=0 and wrap=0.
REQ-030 Reset asserted mid-APPLY or mid-RUN SHALL abandon the command with no done pulse; cmd_ready SHALL be 1 in the first cycle after release.

Structure
REQ-031 Package tff_count_pkg SHALL hold the cmd_op encodings (OP_CLEAR, OP_LOAD, OP_UP, OP_DOWN) and the FSM state enum.
REQ-032 The design SHALL instantiate the team's tff cell (clk, rstn, T, Q) WIDTH times, and SHALL contain no other sub-module.
REQ-033 The FSM, the remaining counter and the toggle-vector logic SHALL reside in tff_count_ctrl.

Verification (WIDTH=8)
REQ-034 Reset release, then LOAD 0xA5: q==0xA5 two edges after acceptance, done pulses exactly once, wrap==0.
REQ-035 LOAD 0xFD, then UP N=5: q steps FE, FF, 00, 01, 02; wrap==1 after the third step; done one cycle after q==0x02.
REQ-036 LOAD 0x03, then DOWN N=3, then DOWN N=2: q ends 0x00 with wrap==0, then 0xFE with wrap==1; a following CLEAR gives q==0x00 and wrap==0.
REQ-037 UP N=0: IDLE->DONE, done pulses, q unchanged, busy never high.
REQ-038 UP N=10 from 0x00 with abort high in the 4th RUN cycle: q==0x03, done pulses next cycle, and a cmd_valid held high during RUN is accepted only after returning to IDLE.
REQ-039 rstn low in the middle of UP N=20: q==0 immediately (asynchronously), no done pulse, cmd_ready==1 in the first cycle after release.
